// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access codes, FSM states and the
// request legality check used at accept time.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTES_W = DATA_W / 8;

    localparam logic [1:0] WR_SB = 2'b00;
    localparam logic [1:0] WR_SH = 2'b01;
    localparam logic [1:0] WR_SW = 2'b10;

    localparam logic [2:0] RD_LB  = 3'b000;
    localparam logic [2:0] RD_LH  = 3'b001;
    localparam logic [2:0] RD_LW  = 3'b010;
    localparam logic [2:0] RD_LBU = 3'b100;
    localparam logic [2:0] RD_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Ctrl-code legality plus natural alignment; range is checked by the owner of the storage.
    function automatic logic accessErr(input logic we, input logic [1:0] wrCtrl,
                                       input logic [2:0] rdCtrl, input logic [1:0] addrLow);
        logic err;
        err = 1'b1;
        if (we) begin
            case (wrCtrl)
                WR_SB:   err = 1'b0;
                WR_SH:   err = addrLow[0];
                WR_SW:   err = (addrLow != 2'b00);
                default: err = 1'b1;
            endcase
        end else begin
            case (rdCtrl)
                RD_LB, RD_LBU: err = 1'b0;
                RD_LH, RD_LHU: err = addrLow[0];
                RD_LW:         err = (addrLow != 2'b00);
                default:       err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit storage word and the CPU's right-justified data:
// store byte enables / replication and load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]        addrLow,
    input  logic [1:0]        wrCtrl,
    input  logic [2:0]        rdCtrl,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [BYTES_W-1:0] byteEn_c,
    output logic [DATA_W-1:0] wdataRep_c,
    output logic [DATA_W-1:0] rdataExt_c
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    always_comb begin
        byteEn_c   = '0;
        wdataRep_c = wdata;
        case (wrCtrl)
            WR_SB: begin
                byteEn_c   = 4'b0001 << addrLow;
                wdataRep_c = {4{wdata[7:0]}};
            end
            WR_SH: begin
                byteEn_c   = addrLow[1] ? 4'b1100 : 4'b0011;
                wdataRep_c = {2{wdata[15:0]}};
            end
            WR_SW:   byteEn_c = 4'b1111;
            default: byteEn_c = '0;
        endcase
    end

    always_comb begin
        selByte    = rword[7:0];
        selHalf    = addrLow[1] ? rword[31:16] : rword[15:0];
        rdataExt_c = '0;
        case (addrLow)
            2'd0:    selByte = rword[7:0];
            2'd1:    selByte = rword[15:8];
            2'd2:    selByte = rword[23:16];
            default: selByte = rword[31:24];
        endcase
        case (rdCtrl)
            RD_LB:   rdataExt_c = {{24{selByte[7]}}, selByte};
            RD_LBU:  rdataExt_c = {24'h0, selByte};
            RD_LH:   rdataExt_c = {{16{selHalf[15]}}, selHalf};
            RD_LHU:  rdataExt_c = {16'h0, selHalf};
            RD_LW:   rdataExt_c = rword;
            default: rdataExt_c = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory slave: one outstanding load/store, fixed response latency,
// byte-enable storage and a load result captured at accept time.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_wr_ctrl,
    input  logic [2:0]        req_rd_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    state_t              state;
    state_t              nextState;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mem [DEPTH_WORDS];
    logic [IDX_W-1:0]    wordIdx;
    logic                accept;
    logic                inRange;
    logic                reqErr;
    logic [BYTES_W-1:0]  byteEn;
    logic [DATA_W-1:0]   wdataRep;
    logic [DATA_W-1:0]   rdataExt;
    logic [DATA_W-1:0]   holdData;
    logic                holdErr;

    assign accept  = req_valid && (state == IDLE);
    assign wordIdx = req_addr[IDX_W+1:2];
    assign inRange = (req_addr[DATA_W-1:IDX_W+2] == '0);
    assign reqErr  = !inRange || accessErr(req_we, req_wr_ctrl, req_rd_ctrl, req_addr[1:0]);

    mem_lane_align uLane (
        .addrLow    (req_addr[1:0]),
        .wrCtrl     (req_wr_ctrl),
        .rdCtrl     (req_rd_ctrl),
        .wdata      (req_wdata),
        .rword      (mem[wordIdx]),
        .byteEn_c   (byteEn),
        .wdataRep_c (wdataRep),
        .rdataExt_c (rdataExt)
    );

    // Storage is deliberately left out of reset; stores commit on the accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_we && !reqErr) begin
            for (int b = 0; b < int'(BYTES_W); b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataRep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = WAIT;
            WAIT:    if (cnt == CNT_W'(RD_LATENCY - 1)) nextState = RESP;
            RESP:    if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Load result is frozen at accept so later stores cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            holdData  <= '0;
            holdErr   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                holdErr  <= reqErr;
                holdData <= (reqErr || req_we) ? '0 : rdataExt;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            req_ready <= (nextState == IDLE);
            rsp_valid <= (nextState == RESP);
            if (nextState == RESP) begin
                if (state == WAIT) begin
                    rsp_rdata <= holdData;
                    rsp_err   <= holdErr;
                end
            end else begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule
